// File: rtl/uart_prog_loader_pkg.sv
// Shared constants for the UART program loader: default frame header and FSM state encodings.
package uart_prog_loader_pkg;

    localparam logic [7:0] SyncByteDefault = 8'h55;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLen  = 2'd1,
        StData = 2'd2,
        StCsum = 2'd3
    } loader_state_e;

    typedef enum logic [1:0] {
        RxIdle  = 2'd0,
        RxStart = 2'd1,
        RxData  = 2'd2,
        RxStop  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Program-RAM write port and loader status, driven by the loader (master) into RAM/host (slave).
interface uart_prog_loader_if;

    logic [7:0] prog_adrs;
    logic [7:0] prog_data;
    logic       prog_wr_en;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output prog_adrs,
        output prog_data,
        output prog_wr_en,
        output busy,
        output done,
        output err
    );

    modport slave (
        input prog_adrs,
        input prog_data,
        input prog_wr_en,
        input busy,
        input done,
        input err
    );

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling and start-bit glitch rejection.
module uart_rx
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam logic [15:0] HalfLast = 16'((CLKS_PER_BIT / 2) - 1);
    localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);

    logic        sync_1;
    logic        sync_2;
    logic        line_prev;
    rx_state_e   state;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_1    <= 1'b1;
            sync_2    <= 1'b1;
            line_prev <= 1'b1;
            state     <= RxIdle;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            rx_ferr   <= 1'b0;
        end else begin
            sync_1    <= rxd;
            sync_2    <= sync_1;
            line_prev <= sync_2;
            rx_valid  <= 1'b0;
            rx_ferr   <= 1'b0;
            unique case (state)
                RxIdle: begin
                    if (line_prev && !sync_2) begin
                        state   <= RxStart;
                        clk_cnt <= '0;
                    end
                end
                RxStart: begin
                    if (clk_cnt == HalfLast) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        // Line back high at the midpoint: a glitch, not a start bit.
                        state   <= sync_2 ? RxIdle : RxData;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                RxData: begin
                    if (clk_cnt == BitLast) begin
                        clk_cnt <= '0;
                        shift   <= {sync_2, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= RxStop;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                RxStop: begin
                    if (clk_cnt == BitLast) begin
                        clk_cnt <= '0;
                        state   <= RxIdle;
                        if (sync_2) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= shift;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                default: state <= RxIdle;
            endcase
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Receives framed program images over UART (SYNC, LEN, DATA x N, CSUM) and writes them to RAM.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = SyncByteDefault
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                rxd,
    uart_prog_loader_if.master  prog
);

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_ferr;
    loader_state_e state;
    logic [7:0]    adr_cnt;
    logic [7:0]    csum;
    logic [8:0]    data_cnt;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clock    (clock),
        .reset    (reset),
        .rxd      (rxd),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= StIdle;
            adr_cnt         <= '0;
            csum            <= '0;
            data_cnt        <= '0;
            prog.prog_adrs  <= '0;
            prog.prog_data  <= '0;
            prog.prog_wr_en <= 1'b0;
            prog.busy       <= 1'b0;
            prog.done       <= 1'b0;
            prog.err        <= 1'b0;
        end else begin
            prog.prog_wr_en <= 1'b0;
            if (rx_ferr) begin
                if (state != StIdle) begin
                    state     <= StIdle;
                    prog.busy <= 1'b0;
                    prog.err  <= 1'b1;
                end
            end else if (rx_valid) begin
                unique case (state)
                    StIdle: begin
                        if (rx_byte == SYNC_BYTE) begin
                            state     <= StLen;
                            prog.busy <= 1'b1;
                            prog.done <= 1'b0;
                            prog.err  <= 1'b0;
                        end
                    end
                    StLen: begin
                        // A length byte of zero encodes a full 256-byte page.
                        data_cnt <= (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
                        adr_cnt  <= '0;
                        csum     <= '0;
                        state    <= StData;
                    end
                    StData: begin
                        prog.prog_adrs  <= adr_cnt;
                        prog.prog_data  <= rx_byte;
                        prog.prog_wr_en <= 1'b1;
                        adr_cnt         <= adr_cnt + 8'd1;
                        csum            <= csum + rx_byte;
                        data_cnt        <= data_cnt - 9'd1;
                        if (data_cnt == 9'd1) begin
                            state <= StCsum;
                        end
                    end
                    StCsum: begin
                        if (rx_byte == csum) begin
                            prog.done <= 1'b1;
                        end else begin
                            prog.err <= 1'b1;
                        end
                        state     <= StIdle;
                        prog.busy <= 1'b0;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed self-checking bench for uart_prog_loader at 16 clocks per UART bit.
module tb_uart_prog_loader;
    import uart_prog_loader_pkg::*;

    localparam int unsigned Cpb = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rxd   = 1'b1;

    uart_prog_loader_if prog_bus ();

    uart_prog_loader #(
        .CLKS_PER_BIT (Cpb),
        .SYNC_BYTE    (8'h55)
    ) dut (
        .clock (clock),
        .reset (reset),
        .rxd   (rxd),
        .prog  (prog_bus)
    );

    always #5 clock = ~clock;

    int n_checks  = 0;
    int n_fail    = 0;
    int rv_cnt    = 0;
    int bad_lat   = 0;
    int bad_pulse = 0;
    logic rv_prev = 1'b0;
    logic wr_prev = 1'b0;
    logic [7:0] wr_adrs_q[$];
    logic [7:0] wr_data_q[$];

    // Capture every write and flag any strobe that is not exactly one cycle after rx_valid.
    always @(negedge clock) begin
        if (prog_bus.prog_wr_en) begin
            wr_adrs_q.push_back(prog_bus.prog_adrs);
            wr_data_q.push_back(prog_bus.prog_data);
            if (!rv_prev) bad_lat++;
            if (wr_prev) bad_pulse++;
        end
        if (dut.rx_valid) rv_cnt++;
        rv_prev = dut.rx_valid;
        wr_prev = prog_bus.prog_wr_en;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        @(negedge clock) rxd = 1'b0;
        repeat (Cpb) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (Cpb) @(negedge clock);
        end
        rxd = stop_bit;
        repeat (Cpb) @(negedge clock);
        rxd = 1'b1;
        repeat (Cpb) @(negedge clock);
    endtask

    task automatic clear_writes();
        wr_adrs_q.delete();
        wr_data_q.delete();
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [7:0] a,
                            input logic [7:0] d);
        logic [7:0] oa;
        logic [7:0] od;
        oa = (idx < wr_adrs_q.size()) ? wr_adrs_q[idx] : 8'hxx;
        od = (idx < wr_data_q.size()) ? wr_data_q[idx] : 8'hxx;
        check_eq({tag, " adrs"}, {24'd0, oa}, {24'd0, a});
        check_eq({tag, " data"}, {24'd0, od}, {24'd0, d});
    endtask

    initial begin
        int rv_base;
        int wr_base;
        logic [7:0] b;

        // Reset state
        repeat (5) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_eq("rst adrs", prog_bus.prog_adrs, 8'h00);
        check_eq("rst data", prog_bus.prog_data, 8'h00);
        check_eq("rst wr_en", prog_bus.prog_wr_en, 1'b0);
        check_eq("rst busy", prog_bus.busy, 1'b0);
        check_eq("rst done", prog_bus.done, 1'b0);
        check_eq("rst err", prog_bus.err, 1'b0);

        // Good 3-byte frame
        clear_writes();
        send_byte(8'h55);
        send_byte(8'h03);
        check_eq("f1 busy mid", prog_bus.busy, 1'b1);
        send_byte(8'h3E);
        send_byte(8'h01);
        send_byte(8'hC6);
        send_byte(8'h05);
        repeat (10) @(negedge clock);
        check_eq("f1 nwr", wr_adrs_q.size(), 3);
        check_wr("f1 w0", 0, 8'h00, 8'h3E);
        check_wr("f1 w1", 1, 8'h01, 8'h01);
        check_wr("f1 w2", 2, 8'h02, 8'hC6);
        check_eq("f1 done", prog_bus.done, 1'b1);
        check_eq("f1 err", prog_bus.err, 1'b0);
        check_eq("f1 busy", prog_bus.busy, 1'b0);

        // 6-cycle glitch while idle
        rv_base = rv_cnt;
        @(negedge clock) rxd = 1'b0;
        repeat (6) @(negedge clock);
        rxd = 1'b1;
        repeat (40) @(negedge clock);
        check_eq("glitch rx_valid", rv_cnt - rv_base, 0);
        check_eq("glitch err", prog_bus.err, 1'b0);
        check_eq("glitch busy", prog_bus.busy, 1'b0);

        // Bad checksum
        clear_writes();
        send_byte(8'h55);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h31);
        repeat (10) @(negedge clock);
        check_eq("f2 nwr", wr_adrs_q.size(), 2);
        check_wr("f2 w0", 0, 8'h00, 8'h10);
        check_wr("f2 w1", 1, 8'h01, 8'h20);
        check_eq("f2 err", prog_bus.err, 1'b1);
        check_eq("f2 done", prog_bus.done, 1'b0);

        // Junk before sync; payload equal to sync byte value is data
        clear_writes();
        send_byte(8'hAA);
        send_byte(8'h12);
        check_eq("f3 junk nwr", wr_adrs_q.size(), 0);
        check_eq("f3 junk busy", prog_bus.busy, 1'b0);
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h80);
        send_byte(8'h80);
        repeat (10) @(negedge clock);
        check_eq("f3 nwr", wr_adrs_q.size(), 1);
        check_wr("f3 w0", 0, 8'h00, 8'h80);
        check_eq("f3 done", prog_bus.done, 1'b1);
        check_eq("f3 err", prog_bus.err, 1'b0);

        clear_writes();
        send_byte(8'h55);
        send_byte(8'h02);
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h56);
        repeat (10) @(negedge clock);
        check_eq("f4 nwr", wr_adrs_q.size(), 2);
        check_wr("f4 w0", 0, 8'h00, 8'h55);
        check_eq("f4 done", prog_bus.done, 1'b1);

        // Full 256-byte page, sum of 0..255 = 0x7F80
        clear_writes();
        send_byte(8'h55);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            send_byte(b);
        end
        send_byte(8'h80);
        repeat (10) @(negedge clock);
        check_eq("f5 nwr", wr_adrs_q.size(), 256);
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            check_wr("f5 w", i, b, b);
        end
        check_eq("f5 done", prog_bus.done, 1'b1);
        check_eq("f5 err", prog_bus.err, 1'b0);
        check_eq("f5 adr_cnt", dut.adr_cnt, 8'h00);

        // Framing error on the second data byte
        clear_writes();
        send_byte(8'h55);
        send_byte(8'h04);
        send_byte(8'hA1);
        send_byte(8'hB2, 1'b0);
        repeat (10) @(negedge clock);
        check_eq("f6 nwr", wr_adrs_q.size(), 1);
        check_wr("f6 w0", 0, 8'h00, 8'hA1);
        check_eq("f6 err", prog_bus.err, 1'b1);
        check_eq("f6 done", prog_bus.done, 1'b0);
        check_eq("f6 busy", prog_bus.busy, 1'b0);
        check_eq("f6 state", dut.state, StIdle);

        // Reset in the middle of DATA
        clear_writes();
        send_byte(8'h55);
        send_byte(8'h05);
        send_byte(8'h11);
        send_byte(8'h22);
        check_eq("f7 busy pre", prog_bus.busy, 1'b1);
        @(negedge clock) reset = 1'b1;
        @(negedge clock) reset = 1'b0;
        check_eq("f7 rst adrs", prog_bus.prog_adrs, 8'h00);
        check_eq("f7 rst data", prog_bus.prog_data, 8'h00);
        check_eq("f7 rst wr_en", prog_bus.prog_wr_en, 1'b0);
        check_eq("f7 rst busy", prog_bus.busy, 1'b0);
        check_eq("f7 rst done", prog_bus.done, 1'b0);
        check_eq("f7 rst err", prog_bus.err, 1'b0);
        check_eq("f7 rst csum", dut.csum, 8'h00);
        check_eq("f7 rst dcnt", dut.data_cnt, 9'h000);
        wr_base = wr_adrs_q.size();
        check_eq("f7 pre nwr", wr_base, 2);
        send_byte(8'h33);
        send_byte(8'h44);
        repeat (10) @(negedge clock);
        check_eq("f7 post nwr", wr_adrs_q.size() - wr_base, 0);
        check_eq("f7 post busy", prog_bus.busy, 1'b0);

        check_eq("wr latency", bad_lat, 0);
        check_eq("wr pulse width", bad_pulse, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
